// File: rtl/pc_fetch_sequencer_pkg.sv
// kgp_pkg: shared KGP_RISC fetch types, widths and reset defaults.
package kgp_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    VALID = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } state_t;
endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// pc_fetch_sequencer_if: imem req/ack, downstream valid/ready and branch redirect bundle.
interface pc_fetch_sequencer_if;
  import kgp_pkg::*;
  logic imem_req;
  logic [XLEN-1:0] imem_addr;
  logic imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic instr_valid;
  logic instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc_out;
  logic br_valid;
  logic PCSrc;
  logic [XLEN-1:0] exNPC;
  logic halt;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc_out,
    input  imem_ack, imem_rdata, instr_ready, br_valid, PCSrc, exNPC, halt
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc_out,
    output imem_ack, imem_rdata, instr_ready, br_valid, PCSrc, exNPC, halt
  );
endinterface

// File: rtl/pc_fetch_sequencer_perf.sv
// pcseq_perf_counters: free-running accepted-fetch and redirect counters, wrap silently.
module pcseq_perf_counters import kgp_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic fetchInc,
  input  logic redirectInc,
  output logic [XLEN-1:0] fetch_cnt,
  output logic [XLEN-1:0] redirect_cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      redirect_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + XLEN'(fetchInc);
      redirect_cnt <= redirect_cnt + XLEN'(redirectInc);
    end
  end
endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC, fetches from imem and steers on branch redirects.
// Optional PCSEQ_PERF_CNT_EN adds fetch_cnt/redirect_cnt outputs.
module pc_fetch_sequencer import kgp_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] PC_STEP = 1
) (
  input logic clk,
  input logic rst_n,
  pc_fetch_sequencer_if.master bus
`ifdef PCSEQ_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] fetch_cnt,
  output logic [XLEN-1:0] redirect_cnt
`endif
);
  state_t state, stateNext;
  logic [XLEN-1:0] fetchPc, fetchPcNext, tgt, tgtNext, instrQ, instrNext, pcOutQ, pcOutNext;
  logic redirect;
  assign redirect = bus.br_valid & bus.PCSrc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= stateNext;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchPc <= RESET_PC;
      tgt <= RESET_PC;
      instrQ <= '0;
      pcOutQ <= '0;
    end else begin
      fetchPc <= fetchPcNext;
      tgt <= tgtNext;
      instrQ <= instrNext;
      pcOutQ <= pcOutNext;
    end
  end
  // DRAIN keeps the original request on the bus; the pending target lives in tgt.
  always_comb begin
    stateNext = state;
    fetchPcNext = fetchPc;
    tgtNext = tgt;
    instrNext = instrQ;
    pcOutNext = pcOutQ;
    case (state)
      IDLE: stateNext = REQ;
      REQ: begin
        if (bus.imem_ack && !redirect) begin
          instrNext = bus.imem_rdata;
          pcOutNext = fetchPc;
          fetchPcNext = fetchPc + PC_STEP;
          stateNext = VALID;
        end else if (bus.imem_ack) begin
          fetchPcNext = bus.exNPC;
        end else if (redirect) begin
          tgtNext = bus.exNPC;
          stateNext = DRAIN;
        end
      end
      DRAIN: begin
        tgtNext = redirect ? bus.exNPC : tgt;
        if (bus.imem_ack) begin
          fetchPcNext = redirect ? bus.exNPC : tgt;
          stateNext = REQ;
        end
      end
      VALID: begin
        if (redirect) begin
          fetchPcNext = bus.exNPC;
          stateNext = REQ;
        end else if (bus.instr_ready) begin
          stateNext = bus.halt ? HALT : REQ;
        end
      end
      default: stateNext = state;
    endcase
  end
  assign bus.imem_req = (state == REQ) || (state == DRAIN);
  assign bus.imem_addr = fetchPc;
  assign bus.instr_valid = state == VALID;
  assign bus.instr = instrQ;
  assign bus.pc_out = pcOutQ;
`ifdef PCSEQ_PERF_CNT_EN
  pcseq_perf_counters u_perf (
    .clk(clk),
    .rst_n(rst_n),
    .fetchInc(bus.instr_valid & bus.instr_ready & !redirect),
    .redirectInc(redirect & ((state == REQ) || (state == DRAIN) || (state == VALID))),
    .fetch_cnt(fetch_cnt),
    .redirect_cnt(redirect_cnt)
  );
`endif
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: random imem latency, backpressure, redirects and halts vs a fetch-stream model.
module tb_pc_fetch_sequencer;
  logic clk, rst_n;
  int total, bad, haltLeft;
  logic [31:0] expPc, expAddr, expPcOut, expInstr, curPc, curInstr, fc, rc;
  bit expReq, expValid, stale, redir;
  pc_fetch_sequencer_if bus ();
`ifdef PCSEQ_PERF_CNT_EN
  logic [31:0] fetch_cnt, redirect_cnt;
  pc_fetch_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus), .fetch_cnt(fetch_cnt), .redirect_cnt(redirect_cnt));
`else
  pc_fetch_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  function automatic logic [31:0] memWord(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask
  task automatic resetPulse();
    #2 rst_n = 0;
    #1;
    check("rst_req", bus.imem_req, 0);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_pc_out", bus.pc_out, 0);
    check("rst_instr", bus.instr, 0);
`ifdef PCSEQ_PERF_CNT_EN
    check("rst_fetch_cnt", fetch_cnt, 0);
    check("rst_redirect_cnt", redirect_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1;
    expPc = 0; stale = 0; expReq = 1; expAddr = 0; expValid = 0; haltLeft = 0; fc = 0; rc = 0;
    #1 check("idle_bubble", bus.imem_req, 0);
  endtask
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    total = 0; bad = 0; rst_n = 0;
    bus.imem_ack = 0; bus.imem_rdata = 0; bus.instr_ready = 0;
    bus.br_valid = 0; bus.PCSrc = 0; bus.exNPC = 0; bus.halt = 0;
    repeat (2) @(negedge clk);
    resetPulse();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      check("req_valid_excl", bus.imem_req & bus.instr_valid, 0);
`ifdef PCSEQ_PERF_CNT_EN
      check("fetch_cnt", fetch_cnt, fc);
      check("redirect_cnt", redirect_cnt, rc);
`endif
      if (haltLeft > 0) begin
        check("halt_req", bus.imem_req, 0);
        check("halt_valid", bus.instr_valid, 0);
        haltLeft--;
        if (haltLeft == 0) resetPulse();
        continue;
      end
      if (expReq) begin
        check("req_high", bus.imem_req, 1);
        check("req_addr", bus.imem_addr, expAddr);
      end
      if (expValid) begin
        check("valid_high", bus.instr_valid, 1);
        check("pc_out", bus.pc_out, expPcOut);
        check("instr", bus.instr, expInstr);
      end
      bus.imem_ack = 1'($urandom_range(0, 1));
      bus.imem_rdata = memWord(bus.imem_addr);
      bus.instr_ready = $urandom_range(0, 9) < 7;
      bus.br_valid = $urandom_range(0, 9) < 2;
      bus.PCSrc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: bus.exNPC = 32'hFFFF_FFFF;
        1: bus.exNPC = $urandom;
        default: bus.exNPC = $urandom_range(0, 64);
      endcase
      bus.halt = $urandom_range(0, 29) == 0;
      redir = bus.br_valid & bus.PCSrc;
      expReq = 0;
      expValid = 0;
      if (bus.instr_valid) begin
        if (redir) begin
          rc++;
          expPc = bus.exNPC; expReq = 1; expAddr = expPc;
        end else if (bus.instr_ready) begin
          fc++;
          if (bus.halt) haltLeft = 20;
          else begin expReq = 1; expAddr = expPc; end
        end else begin
          expValid = 1; expPcOut = curPc; expInstr = curInstr;
        end
      end else if (bus.imem_req) begin
        if (redir) rc++;
        if (bus.imem_ack && (stale || redir)) begin
          if (redir) expPc = bus.exNPC;
          stale = 0; expReq = 1; expAddr = expPc;
        end else if (bus.imem_ack) begin
          check("fetch_addr", bus.imem_addr, expPc);
          curPc = expPc; curInstr = memWord(expPc);
          expValid = 1; expPcOut = curPc; expInstr = curInstr;
          expPc = expPc + 1;
        end else begin
          if (redir) begin expPc = bus.exNPC; stale = 1; end
          expReq = 1;
        end
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the architectural PC and fetches one instruction at a time from instruction memory over a req/ack handshake.
- Presents each fetched instruction and its PC downstream over a valid/ready handshake; that PC feeds the branchlogic PC input.
- Consumes the branchlogic redirect (PCSrc, exNPC) and steers fetch to the target, squashing wrong-path instructions.
- Sits between imem and decode/execute in KGP_RISC.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_STEP, 1, increment per sequential instruction (word-addressed imem).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  32  fetch address; stable while imem_req=1.
- imem_ack  in  1  one-cycle acknowledge; imem_rdata valid the same cycle.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr/pc_out hold a valid instruction.
- instr_ready  in  1  downstream accepts when high with instr_valid.
- instr  out  32  fetched instruction.
- pc_out  out  32  PC of instr (to branchlogic PC).
- br_valid  in  1  qualifies PCSrc/exNPC this cycle.
- PCSrc  in  1  redirect taken (from branchlogic).
- exNPC  in  32  redirect target (from branchlogic).
- halt  in  1  stop fetching after the current instruction is accepted.

Behaviour:
- redirect = br_valid & PCSrc.
- Reset (async assert, sync release): state=IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, pc_out=0.
- Registered outputs only; no combinational path from inputs to outputs.
- imem_addr always equals fetch_pc.

States and transitions:
- IDLE: one bubble cycle after reset release, then REQ.
- REQ: imem_req=1.
  - imem_ack & !redirect: instr<=imem_rdata, pc_out<=fetch_pc, fetch_pc<=fetch_pc+PC_STEP, go VALID.
  - imem_ack & redirect: data discarded, fetch_pc<=exNPC, stay REQ.
  - !imem_ack & redirect: tgt<=exNPC, go DRAIN; the in-flight request is never withdrawn.
- DRAIN: imem_req=1 with the old address.
  - Further redirects overwrite tgt (latest wins).
  - On imem_ack: data discarded, fetch_pc<=(redirect ? exNPC : tgt), go REQ.
- VALID: instr_valid=1. Redirect has priority over everything:
  - redirect: instr_valid<=0, fetch_pc<=exNPC, go REQ. A coincident instr_ready handshake is void.
  - else instr_ready & halt: go HALT.
  - else instr_ready: go REQ.
  - else hold instr/pc_out stable.
- HALT: imem_req=0, instr_valid=0; exit only via rst_n.

Timing and arithmetic:
- Latency: redirect in cycle N (REQ with ack, or VALID) means imem_addr=exNPC with imem_req=1 in cycle N+1.
- Sustained throughput: one instruction per 2 cycles minimum with zero-wait imem.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFF + 1 wraps to 0 with no flag.
- imem_ack outside REQ/DRAIN is ignored.
- Reset mid-fetch abandons the transaction; imem must tolerate a dropped request.

Optional Feature:
- Macro PCSEQ_PERF_CNT_EN.
- When defined, adds these outputs, cleared by rst_n:
  - fetch_cnt (32): increments on each accepted instruction (instr_valid & instr_ready & !redirect).
  - redirect_cnt (32): increments on each redirect cycle in REQ, DRAIN or VALID.
  - Both wrap silently.
- When undefined, the ports and logic are absent; other behaviour is unchanged.

Decomposition:
- Shared package kgp_pkg holds:
  - state encoding constants IDLE/REQ/VALID/DRAIN/HALT (3-bit);
  - XLEN=32;
  - RESET_PC default.
- One sub-module, pcseq_perf_counters, holding both counters, instantiated only under PCSEQ_PERF_CNT_EN.

Test Plan:
- Reset release with RESET_PC=0, imem acking every request, instr_ready=1 -> pc_out sequence 0,1,2,3 on successive handshakes; imem_req low on the first cycle after release.
- Instruction at pc_out=5 held in VALID, br_valid=1, PCSrc=1, exNPC=32'h0000_0040, instr_ready=1 same cycle -> handshake void, instr_valid=0, next imem_addr=32'h40, next pc_out=32'h40.
- Redirect to 32'h100 while REQ at 7 is waiting 3 cycles for ack, then a second redirect to 32'h200 in DRAIN -> data at 7 discarded, next request addr=32'h200.
- fetch_pc=32'hFFFF_FFFF accepted -> next imem_addr=0.
- halt=1 with handshake at pc_out=9 -> imem_req stays 0 for ≥20 cycles, instr_valid=0; rst_n pulse -> fetch resumes at RESET_PC.
- Under PCSEQ_PERF_CNT_EN, 10 accepted instructions plus 2 redirects -> fetch_cnt=10, redirect_cnt=2; assert rst_n mid-run -> both 0 immediately.
